// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types for the AXI4-Stream packet arbiter: FSM state encoding and
// the index-width helper used by the top and the round-robin picker.
package logic_axi4_stream_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle; the tx modport is the driving side, rx the receiving side.
interface logic_axi4_stream_if #(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
) ();
  logic                       tvalid;
  logic                       tready;
  logic [8*TDATA_BYTES-1:0]   tdata;
  logic [TDATA_BYTES-1:0]     tkeep;
  logic [TDATA_BYTES-1:0]     tstrb;
  logic                       tlast;
  logic [TUSER_WIDTH-1:0]     tuser;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TID_WIDTH-1:0]       tid;

  modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
              input  tready);
  modport rx (input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
              output tready);
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant
// (wrapping modulo INPUTS) wins; one-hot result, zero when nobody requests.
module logic_axi4_stream_packet_arbiter_rr
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS = 2,
  localparam int unsigned IDX_W = idx_width(INPUTS)
) (
  input  logic [INPUTS-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [INPUTS-1:0] gnt
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= INPUTS; k++) begin
      idx = (32'(last_grant) + k) % INPUTS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-granular round-robin arbiter of INPUTS AXI4-Stream requesters onto one
// registered output. Optional macro LOGIC_AXI4_STREAM_PACKET_ARBITER_TDEST_TAG_EN
// replaces tx.tdest with the winning input index.
module logic_axi4_stream_packet_arbiter
  import logic_axi4_stream_packet_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned USE_TLAST   = 1,
  parameter int unsigned USE_TKEEP   = 1,
  parameter int unsigned USE_TSTRB   = 1
) (
  input  logic               aclk,
  input  logic               areset_n,
  logic_axi4_stream_if.rx    rx [INPUTS],
  logic_axi4_stream_if.tx    tx,
  output logic [INPUTS-1:0]  grant,
  output logic               busy
);

  localparam int unsigned DW    = 8 * TDATA_BYTES;
  localparam int unsigned IDX_W = idx_width(INPUTS);

  if (INPUTS < 2 || INPUTS > 16) begin : g_bad_inputs
    $error("INPUTS must be in 2..16");
  end

`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TDEST_TAG_EN
  if (TDEST_WIDTH < IDX_W) begin : g_bad_tdest
    $error("TDEST_WIDTH too narrow to carry the input index");
  end
`endif

  logic [INPUTS-1:0]      rx_tvalid;
  logic [INPUTS-1:0]      rx_tready;
  logic [INPUTS-1:0]      rx_tlast;
  logic [DW-1:0]          rx_tdata [INPUTS];
  logic [TDATA_BYTES-1:0] rx_tkeep [INPUTS];
  logic [TDATA_BYTES-1:0] rx_tstrb [INPUTS];
  logic [TUSER_WIDTH-1:0] rx_tuser [INPUTS];
  logic [TDEST_WIDTH-1:0] rx_tdest [INPUTS];
  logic [TID_WIDTH-1:0]   rx_tid   [INPUTS];

  for (genvar i = 0; i < INPUTS; i++) begin : g_rx
    assign rx_tvalid[i] = rx[i].tvalid;
    assign rx_tlast[i]  = rx[i].tlast;
    assign rx_tdata[i]  = rx[i].tdata;
    assign rx_tkeep[i]  = rx[i].tkeep;
    assign rx_tstrb[i]  = rx[i].tstrb;
    assign rx_tuser[i]  = rx[i].tuser;
    assign rx_tdest[i]  = rx[i].tdest;
    assign rx_tid[i]    = rx[i].tid;
    assign rx[i].tready = rx_tready[i];
  end

  arb_state_t        state, state_nxt;
  logic [INPUTS-1:0] grant_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic              tvalid_q;

  logic [INPUTS-1:0] rr_gnt;
  logic [IDX_W-1:0]  rr_idx;
  logic              out_ready;
  logic              sel_valid;
  logic              sel_last;
  logic              beat_acc;

  logic_axi4_stream_packet_arbiter_rr #(
    .INPUTS (INPUTS)
  ) u_rr (
    .req        (rx_tvalid),
    .last_grant (last_grant_q),
    .gnt        (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (rr_gnt[i]) rr_idx = IDX_W'(i);
    end
  end

  // Without tlast every beat closes its own packet, so arbitration is per beat.
  assign out_ready = !tvalid_q || tx.tready;
  assign sel_valid = rx_tvalid[gidx_q];
  assign sel_last  = (USE_TLAST != 0) ? rx_tlast[gidx_q] : 1'b1;
  assign beat_acc  = (state == LOCKED) && sel_valid && out_ready;

  always_comb begin
    state_nxt = state;
    rx_tready = '0;
    case (state)
      IDLE: begin
        if (|rx_tvalid) state_nxt = LOCKED;
      end
      LOCKED: begin
        rx_tready = grant_q & {INPUTS{out_ready}};
        if (beat_acc && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IDX_W'(INPUTS - 1);
      tvalid_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |rx_tvalid) begin
        grant_q <= rr_gnt;
        gidx_q  <= rr_idx;
      end
      if (beat_acc && sel_last) begin
        grant_q      <= '0;
        last_grant_q <= gidx_q;
      end
      if (beat_acc)        tvalid_q <= 1'b1;
      else if (tx.tready)  tvalid_q <= 1'b0;
    end
  end

  logic [DW-1:0]          data_q;
  logic [TDATA_BYTES-1:0] keep_q;
  logic [TDATA_BYTES-1:0] strb_q;
  logic                   last_q;
  logic [TUSER_WIDTH-1:0] user_q;
  logic [TDEST_WIDTH-1:0] dest_q;
  logic [TID_WIDTH-1:0]   id_q;

  // The index tag is captured with the beat so it stays right while tx stalls
  // after the grant has already moved on.
  always_ff @(posedge aclk) begin
    if (beat_acc) begin
      data_q <= rx_tdata[gidx_q];
      keep_q <= rx_tkeep[gidx_q];
      strb_q <= rx_tstrb[gidx_q];
      last_q <= rx_tlast[gidx_q];
      user_q <= rx_tuser[gidx_q];
      id_q   <= rx_tid[gidx_q];
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TDEST_TAG_EN
      dest_q <= TDEST_WIDTH'(gidx_q);
`else
      dest_q <= rx_tdest[gidx_q];
`endif
    end
  end

  assign tx.tvalid = tvalid_q;
  assign tx.tdata  = data_q;
  assign tx.tkeep  = (USE_TKEEP != 0) ? keep_q : '1;
  assign tx.tstrb  = (USE_TSTRB != 0) ? strb_q : '1;
  assign tx.tlast  = (USE_TLAST != 0) ? last_q : 1'b1;
  assign tx.tuser  = user_q;
  assign tx.tdest  = dest_q;
  assign tx.tid    = id_q;

  assign grant = grant_q;
  assign busy  = (state == LOCKED);

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Scoreboard bench: packets are queued per requester and as one expected tx
// order; a negedge monitor checks tx beats, rx grants, stalls and bubbles.
module tb_logic_axi4_stream_packet_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic       first;
    logic [1:0] src;
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       last;
    logic       user;
    logic [1:0] dest;
  } beat_t;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 aclk = ~aclk;

  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2)) rx_if [N] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2)) tx_if ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2)) rx2_if [N] ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2)) tx2_if ();

  logic [N-1:0] grant, grant2;
  logic         busy, busy2;

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(4), .TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2),
    .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .rx(rx_if), .tx(tx_if), .grant(grant), .busy(busy)
  );

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(4), .TDATA_BYTES(1), .TUSER_WIDTH(1), .TDEST_WIDTH(2), .TID_WIDTH(2),
    .USE_TLAST(0), .USE_TKEEP(0), .USE_TSTRB(0)
  ) dut_beat (
    .aclk(aclk), .areset_n(rst2_n), .rx(rx2_if), .tx(tx2_if), .grant(grant2), .busy(busy2)
  );

  beat_t        cur [N];
  logic [N-1:0] d_tvalid = '0;
  logic [N-1:0] d_tready;
  logic         tx_ready = 1'b1;
  logic [5:0]   cnt2 [N];
  logic [N-1:0] d2_tready;

  for (genvar gi = 0; gi < N; gi++) begin : g_drv
    assign rx_if[gi].tvalid = d_tvalid[gi];
    assign rx_if[gi].tdata  = cur[gi].data;
    assign rx_if[gi].tkeep  = cur[gi].keep;
    assign rx_if[gi].tstrb  = cur[gi].strb;
    assign rx_if[gi].tlast  = cur[gi].last;
    assign rx_if[gi].tuser  = cur[gi].user;
    assign rx_if[gi].tdest  = cur[gi].dest;
    assign rx_if[gi].tid    = cur[gi].src;
    assign d_tready[gi]     = rx_if[gi].tready;

    assign rx2_if[gi].tvalid = 1'b1;
    assign rx2_if[gi].tdata  = {2'(gi), cnt2[gi]};
    assign rx2_if[gi].tkeep  = 1'b0;
    assign rx2_if[gi].tstrb  = 1'b0;
    assign rx2_if[gi].tlast  = 1'b0;
    assign rx2_if[gi].tuser  = 1'b0;
    assign rx2_if[gi].tdest  = 2'b00;
    assign rx2_if[gi].tid    = 2'(gi);
    assign d2_tready[gi]     = rx2_if[gi].tready;
  end
  assign tx_if.tready  = tx_ready;
  assign tx2_if.tready = 1'b1;

  beat_t drv_q [N][$];
  beat_t exp_tx [$];
  beat_t exp_rx [$];

  int total = 0;
  int bad = 0;
  int mode = 0;        // tx_ready: 0 constant high, 1 random, 2 pattern 1,0,0,1
  bit gaps = 1'b0;     // random tvalid gaps between beats of a packet
  bit timing_chk = 1'b0;
  int last_src = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.first = (k == 0);
      b.src   = 2'(src);
      b.data  = 8'($urandom);
      b.keep  = 1'($urandom);
      b.strb  = 1'($urandom);
      b.last  = (k == len - 1);
      b.user  = 1'($urandom);
      b.dest  = 2'($urandom);
      drv_q[src].push_back(b);
      exp_tx.push_back(b);
      exp_rx.push_back(b);
    end
    last_src = src;
  endtask

  function automatic logic [15:0] exp_pl(input beat_t b);
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TDEST_TAG_EN
    return {b.data, b.keep, b.strb, b.last, b.user, b.src, b.src};
`else
    return {b.data, b.keep, b.strb, b.last, b.user, b.dest, b.src};
`endif
  endfunction

  // Driver: handshakes seen at negedge retire beats; new values go out at posedge+1.
  logic [N-1:0] hs, hs2;
  int           pidx = 0;
  logic [3:0]   pat = 4'b1001;
  initial begin
    for (int i = 0; i < N; i++) begin
      cur[i]  = '0;
      cnt2[i] = '0;
    end
    forever begin
      @(negedge aclk);
      hs  = d_tvalid & d_tready;
      hs2 = d2_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs2[i]) cnt2[i] = cnt2[i] + 6'd1;
        if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() == 0) begin
          d_tvalid[i] = 1'b0;
        end else begin
          cur[i] = drv_q[i][0];
          if (hs[i] || !d_tvalid[i])
            d_tvalid[i] = cur[i].first || !gaps || ($urandom_range(3) != 0);
        end
      end
      case (mode)
        1:       tx_ready = 1'($urandom_range(1));
        2:       begin tx_ready = pat[pidx % 4]; pidx++; end
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor.
  int          cyc = 0;
  bit          stall_v = 1'b0;
  logic [15:0] stall_pl;
  bit          have_last = 1'b0;
  int          last_cyc = 0;
  int          k2 = 0;
  int          c2_last = 0;
  initial begin
    beat_t       e;
    logic [15:0] act;
    forever begin
      @(negedge aclk);
      cyc++;
      act = {tx_if.tdata, tx_if.tkeep, tx_if.tstrb, tx_if.tlast, tx_if.tuser, tx_if.tdest, tx_if.tid};
      if (!timing_chk) have_last = 1'b0;
      if (!areset_n) begin
        stall_v   = 1'b0;
        have_last = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (d_tvalid[i] && d_tready[i]) begin
            if (exp_rx.size() == 0) begin
              chk("rx_unexpected", 64'(i), 64'hFF);
            end else begin
              e = exp_rx.pop_front();
              chk("rx_src", 64'(i), 64'(e.src));
              chk("grant_busy", {59'd0, busy, grant}, {59'd0, 1'b1, 4'(1 << e.src)});
            end
          end
        end
        if (stall_v) chk("stall_hold", {47'd0, tx_if.tvalid, act}, {47'd0, 1'b1, stall_pl});
        stall_v = 1'b0;
        if (tx_if.tvalid) begin
          if (!tx_ready) begin
            stall_v  = 1'b1;
            stall_pl = act;
          end else if (exp_tx.size() == 0) begin
            chk("tx_unexpected", 64'(act), 64'hFFFFF);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_beat", 64'(act), 64'(exp_pl(e)));
            if (e.first && have_last) chk("bubble_gap", 64'(cyc - last_cyc), 64'd2);
            if (e.last) begin
              have_last = timing_chk;
              last_cyc  = cyc;
            end
          end
        end
      end
      if (rst2_n && tx2_if.tvalid && k2 < 24) begin
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TDEST_TAG_EN
        chk("beat_mode", {tx2_if.tdata, tx2_if.tkeep, tx2_if.tstrb, tx2_if.tlast, tx2_if.tuser, tx2_if.tdest, tx2_if.tid},
            {2'(k2 % 4), 6'(k2 / 4), 1'b1, 1'b1, 1'b1, 1'b0, 2'(k2 % 4), 2'(k2 % 4)});
`else
        chk("beat_mode", {tx2_if.tdata, tx2_if.tkeep, tx2_if.tstrb, tx2_if.tlast, tx2_if.tuser, tx2_if.tdest, tx2_if.tid},
            {2'(k2 % 4), 6'(k2 / 4), 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'(k2 % 4)});
`endif
        if (k2 > 0) chk("beat_period", 64'(cyc - c2_last), 64'd2);
        c2_last = cyc;
        k2++;
      end
    end
  end

  task automatic phase(input int m, input bit g, input bit t);
    timing_chk = 1'b0;
    @(negedge aclk);
    #1;
    mode       = m;
    gaps       = g;
    timing_chk = t;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_tx.size() > 0 || exp_rx.size() > 0) && n < bound) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #2;
    chk("drain_left", 64'(exp_tx.size() + exp_rx.size()), 64'd0);
    chk("idle_grant_busy", {59'd0, busy, grant}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalid", 64'(tx_if.tvalid), 64'd0);
    chk("rst_tready", 64'(d_tready), 64'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    rst2_n   = 1'b1;

    // Two simultaneous 3-beat packets on rx0 and rx2.
    phase(0, 1'b0, 1'b1);
    add_pkt(0, 3);
    add_pkt(2, 3);
    drain(200);

    // rx0 joins while rx1 is mid-packet.
    phase(0, 1'b0, 1'b1);
    add_pkt(1, 5);
    repeat (4) @(posedge aclk);
    #2;
    add_pkt(0, 3);
    drain(200);

    // Single continuous requester, back-to-back packets.
    phase(0, 1'b0, 1'b1);
    add_pkt(2, 2);
    add_pkt(2, 4);
    add_pkt(2, 1);
    drain(200);

    // Output backpressure pattern during a packet.
    phase(2, 1'b0, 1'b0);
    add_pkt(3, 6);
    drain(300);

    // Saturated requesters with random backpressure and mid-packet gaps.
    phase(1, 1'b1, 1'b0);
    begin
      int start;
      start = (last_src + 1) % N;
      for (int r = 0; r < 5; r++)
        for (int k = 0; k < N; k++)
          add_pkt((start + k) % N, 1 + int'($urandom_range(3)));
    end
    drain(3000);

    // Reset during beat 2 of a 5-beat packet.
    phase(0, 1'b0, 1'b0);
    add_pkt(1, 5);
    n = 0;
    while (exp_rx.size() > 3 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    chk("rst_reach_beat2", 64'(exp_rx.size()), 64'd3);
    @(negedge aclk);
    #2;
    areset_n = 1'b0;
    for (int i = 0; i < N; i++) drv_q[i].delete();
    exp_tx.delete();
    exp_rx.delete();
    #1;
    chk("midrst_tvalid", 64'(tx_if.tvalid), 64'd0);
    chk("midrst_grant_busy", {59'd0, busy, grant}, 64'd0);
    chk("midrst_tready", 64'(d_tready), 64'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    phase(0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) add_pkt(i, 2);
    drain(300);

    n = 0;
    while (k2 < 24 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    chk("beat_mode_count", 64'(k2), 64'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
